// File: rtl/mux_cfg_sequencer.sv
// Break-before-make configuration sequencer for a bank of one-hot TGATE muxes.
// Writes land in a shadow file; a commit blanks changed muxes, then swaps in the new selects.
module mux_cfg_sequencer #(
  parameter int NUM_MUX      = 4,
  parameter int MUX_SIZE     = 8,
  parameter int SEL_W        = 3,
  parameter int ADDR_W       = 2,
  parameter int BREAK_CYCLES = 2
) (
  input  logic                        prog_clk,
  input  logic                        pReset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [SEL_W-1:0]            wr_sel,
  input  logic                        commit_valid,
  output logic                        commit_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  input  logic                        err_clr,
  output logic [NUM_MUX*MUX_SIZE-1:0] mem,
  output logic [NUM_MUX*MUX_SIZE-1:0] mem_inv
);

  localparam int MEM_W = NUM_MUX * MUX_SIZE;
  localparam logic [ADDR_W:0] NUM_MUX_LIM  = (ADDR_W+1)'(NUM_MUX);
  localparam logic [SEL_W:0]  MUX_SIZE_LIM = (SEL_W+1)'(MUX_SIZE);
  localparam logic [3:0]      CNT_INIT     = 4'(BREAK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_MUX-1:0]     mask_q, mask_d;
  logic [SEL_W-1:0]       shadow_sel_q [NUM_MUX];
  logic [SEL_W-1:0]       shadow_sel_d [NUM_MUX];
  logic [NUM_MUX-1:0]     shadow_en_q, shadow_en_d;
  logic [SEL_W-1:0]       active_sel_q [NUM_MUX];
  logic [SEL_W-1:0]       active_sel_d [NUM_MUX];
  logic [NUM_MUX-1:0]     active_en_q, active_en_d;
  logic                   err_q, err_d;
  logic [MEM_W-1:0]       mem_q, mem_d;
  logic [MEM_W-1:0]       mem_inv_q;
  logic                   rdy_q, busy_q, done_q;

  logic wr_fire, commit_fire, wr_legal;

  assign wr_fire     = wr_valid && (state_q == S_IDLE);
  assign commit_fire = commit_valid && (state_q == S_IDLE);
  assign wr_legal    = ({1'b0, wr_addr} < NUM_MUX_LIM) && ({1'b0, wr_sel} < MUX_SIZE_LIM);

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    shadow_sel_d = shadow_sel_q;
    shadow_en_d  = shadow_en_q;
    active_sel_d = active_sel_q;
    active_en_d  = active_en_q;
    err_d        = err_q;
    mem_d        = '0;

    // Set wins over clear when both happen on the same edge.
    if (err_clr) err_d = 1'b0;
    if (wr_fire && !wr_legal) err_d = 1'b1;

    for (int i = 0; i < NUM_MUX; i++) begin
      if (wr_fire && wr_legal && (wr_addr == ADDR_W'(i))) begin
        shadow_sel_d[i] = wr_sel;
        shadow_en_d[i]  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (commit_fire) begin
          for (int i = 0; i < NUM_MUX; i++) begin
            mask_d[i] = {shadow_en_d[i], shadow_sel_d[i]} != {active_en_q[i], active_sel_q[i]};
          end
          cnt_d   = CNT_INIT;
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        if (cnt_q == 4'd0) begin
          active_sel_d = shadow_sel_q;
          active_en_d  = shadow_en_q;
          state_d      = S_MAKE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_MAKE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output image for the coming cycle; changed muxes stay dark for the whole break window.
    for (int i = 0; i < NUM_MUX; i++) begin
      if (active_en_d[i] && !((state_d == S_BREAK) && mask_d[i])) begin
        mem_d[i*MUX_SIZE +: MUX_SIZE] = MUX_SIZE'(1) << active_sel_d[i];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      // NOTE: the shadow/active files are reset explicitly; selects must be lost on reset.
      for (int i = 0; i < NUM_MUX; i++) begin
        shadow_sel_q[i] <= '0;
        active_sel_q[i] <= '0;
      end
      shadow_en_q <= '0;
      active_en_q <= '0;
      err_q     <= 1'b0;
      mem_q     <= '0;
      mem_inv_q <= '1;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      shadow_sel_q <= shadow_sel_d;
      shadow_en_q  <= shadow_en_d;
      active_sel_q <= active_sel_d;
      active_en_q  <= active_en_d;
      err_q        <= err_d;
      mem_q        <= mem_d;
      mem_inv_q    <= ~mem_d;
      rdy_q        <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_MAKE);
    end
  end

  assign wr_ready     = rdy_q;
  assign commit_ready = rdy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign mem          = mem_q;
  assign mem_inv      = mem_inv_q;

endmodule
